// File: rtl/imem_fetch_port.sv
// imem_fetch_port
// Word-organised instruction store with a byte-addressed fetch port and a
// separate program-load write port.
//
// Fetch side: valid/ready request, single-entry registered response, one
// cycle of latency. Each response carries a fault code:
//   00 ok, 01 misaligned, 10 out-of-range, 11 parity error.
// Misaligned is reported in preference to out-of-range. A faulted response
// always carries zero data. fault_count saturates at all-ones.
//
// Load side: aligned, in-range writes update the store at the clock edge.
// Any other write is dropped, and load_err pulses on the following cycle.
// A fetch and a load that hit the same word on the same edge return the old
// word, because the response register samples the store before the write
// lands.
//
// Optional build macro: IMEM_PARITY_EN
//   Each word keeps an even-parity bit that is computed from load_data when
//   the word is written. The load_par_flip input inverts that stored bit so
//   that a parity fault can be provoked on purpose. An aligned, in-range
//   fetch whose parity does not match answers with code 11. Without the
//   macro there is no parity storage, no load_par_flip port, and code 11 is
//   never produced.

module imem_fetch_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  // fetch response
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [1:0]            resp_fault,
  // program load
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic                  load_par_flip,
`endif
  output logic                  load_err,
  // status
  output logic [FCNT_WIDTH-1:0] fault_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word-index limit, sized to match the word-index field of a byte address.
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(DEPTH);

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
`ifdef IMEM_PARITY_EN
  localparam logic [1:0] FLT_PARITY   = 2'b11;
`endif

  // Storage. The store itself is never reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
  logic                  par_q [DEPTH];
`endif

  // Response register and status.
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
  logic [ADDR_WIDTH-1:0] resp_addr_q,  resp_addr_d;
  logic [1:0]            resp_fault_q, resp_fault_d;
  logic                  load_err_q,   load_err_d;
  logic [FCNT_WIDTH-1:0] fcnt_q,       fcnt_d;

  // Request decode.
  logic [IDX_W-1:0]      req_idx;
  logic                  req_misaligned;
  logic                  req_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            req_code;
  logic                  accept;

  // Load decode.
  logic [IDX_W-1:0]      ld_idx;
  logic                  ld_ok;

  // A new request can enter whenever the response slot is empty or is being
  // drained this very cycle.
  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  // Classify the fetch address and read the addressed word.
  always_comb begin
    req_idx        = req_addr[IDX_W+1:2];
    req_misaligned = |req_addr[1:0];
    req_in_range   = req_addr[ADDR_WIDTH-1:2] < DEPTH_LIM;
    rd_word        = mem_q[req_idx];
    if (req_misaligned) begin
      req_code = FLT_MISALIGN;
    end else if (!req_in_range) begin
      req_code = FLT_RANGE;
`ifdef IMEM_PARITY_EN
    end else if ((^rd_word) != par_q[req_idx]) begin
      req_code = FLT_PARITY;
`endif
    end else begin
      req_code = FLT_OK;
    end
  end

  // Classify the load address.
  always_comb begin
    ld_idx = load_addr[IDX_W+1:2];
    ld_ok  = (load_addr[1:0] == 2'b00) && (load_addr[ADDR_WIDTH-1:2] < DEPTH_LIM);
  end

  // Next state of the response slot, the load error pulse and the fault counter.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_addr_d  = resp_addr_q;
    resp_fault_d = resp_fault_q;
    fcnt_d       = fcnt_q;

    if (accept) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = req_addr;
      resp_fault_d = req_code;
      resp_data_d  = (req_code == FLT_OK) ? rd_word : '0;
      if ((req_code != FLT_OK) && (fcnt_q != {FCNT_WIDTH{1'b1}})) begin
        fcnt_d = fcnt_q + FCNT_WIDTH'(1);
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end

    load_err_d = load_en && !ld_ok;
  end

  // Response slot and status registers; an async reset drops any held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      resp_fault_q <= FLT_OK;
      load_err_q   <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_addr_q  <= resp_addr_d;
      resp_fault_q <= resp_fault_d;
      load_err_q   <= load_err_d;
      fcnt_q       <= fcnt_d;
    end
  end

  // Program-load write into the store (and its parity bit when enabled).
  always_ff @(posedge clk) begin
    if (load_en && ld_ok) begin
      mem_q[ld_idx] <= load_data;
`ifdef IMEM_PARITY_EN
      par_q[ld_idx] <= (^load_data) ^ load_par_flip;
`endif
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_addr   = resp_addr_q;
  assign resp_fault  = resp_fault_q;
  assign load_err    = load_err_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the store and the
// response slot. A second instance with a 2-bit fault counter shares every
// input so that counter saturation can be observed.

module tb_imem_fetch_port;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          resp_ready = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
`ifdef IMEM_PARITY_EN
  logic          load_par_flip = 1'b0;
`endif

  logic          req_ready, resp_valid, load_err;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] resp_addr;
  logic [1:0]    resp_fault;
  logic [7:0]    fault_count;

  logic          s_req_ready, s_resp_valid, s_load_err;
  logic [DW-1:0] s_resp_data;
  logic [AW-1:0] s_resp_addr;
  logic [1:0]    s_resp_fault;
  logic [1:0]    s_fault_count;

  always #5 clk = ~clk;

  imem_fetch_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FCNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_addr(resp_addr), .resp_fault(resp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip(load_par_flip),
`endif
    .load_err(load_err), .fault_count(fault_count)
  );

  imem_fetch_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FCNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_addr(req_addr),
    .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_data(s_resp_data),
    .resp_addr(s_resp_addr), .resp_fault(s_resp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip(load_par_flip),
`endif
    .load_err(s_load_err), .fault_count(s_fault_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: word store plus the single response slot.
  bit [31:0] ref_mem [DEPTH];
`ifdef IMEM_PARITY_EN
  bit        ref_par [DEPTH];
`endif
  bit        m_valid;
  bit [31:0] m_data, m_addr;
  bit [1:0]  m_fault;
  bit        m_lerr;
  int        m_faults;

  function automatic bit [1:0] ref_code(input bit [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if ((a >> 2) >= DEPTH) return 2'b10;
`ifdef IMEM_PARITY_EN
    if ((^ref_mem[a >> 2]) != ref_par[a >> 2]) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Predict the effect of the coming edge from the current inputs, then take it.
  task automatic tick();
    bit acc;
    bit [1:0] c;
    acc = req_valid && (!m_valid || resp_ready);
    if (acc) begin
      c       = ref_code(req_addr);
      m_valid = 1'b1;
      m_addr  = req_addr;
      m_fault = c;
      m_data  = (c == 2'b00) ? ref_mem[req_addr >> 2] : 32'h0;
      if (c != 2'b00) m_faults++;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    m_lerr = 1'b0;
    if (load_en) begin
      if (load_addr[1:0] == 2'b00 && (load_addr >> 2) < DEPTH) begin
        ref_mem[load_addr >> 2] = load_data;
`ifdef IMEM_PARITY_EN
        ref_par[load_addr >> 2] = (^load_data) ^ load_par_flip;
`endif
      end else begin
        m_lerr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_addr   = '0;
    m_fault  = '0;
    m_lerr   = 1'b0;
    m_faults = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_addr !== 32'h0 || resp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_resp: valid=%b data=%h addr=%h fault=%b, want 0/0/0/00",
               resp_valid, resp_data, resp_addr, resp_fault);
    end
    n_checks++;
    if (fault_count !== 8'd0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: fault_count=%0d load_err=%b, want 0/0", fault_count, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: req_ready=%b resp_valid=%b, want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_load_fetch();
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'h8C08_0000;
    tick();
    load_addr = 32'h8; load_data = 32'h2009_0005;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lf_req_ready: got %b want 1", req_ready);
    end
    tick();
    req_addr = 32'h8;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h8C08_0000 || resp_addr !== 32'h4 || resp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL lf_first: valid=%b data=%h addr=%h fault=%b, want 1/8c080000/4/00",
               resp_valid, resp_data, resp_addr, resp_fault);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h2009_0005 || resp_addr !== 32'h8 || resp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL lf_second: valid=%b data=%h addr=%h fault=%b, want 1/20090005/8/00",
               resp_valid, resp_data, resp_addr, resp_fault);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lf_drain: resp_valid=%b want 0", resp_valid);
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_data !== 32'h8C08_0000 ||
          resp_addr !== 32'h4 || resp_fault !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: req_ready=%b valid=%b data=%h addr=%h fault=%b, want 0/1/8c080000/4/00",
                 i, req_ready, resp_valid, resp_data, resp_addr, resp_fault);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h2009_0005 || resp_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL bp_next: valid=%b data=%h addr=%h, want 1/20090005/8", resp_valid, resp_data, resp_addr);
    end
    tick();
  endtask

  task automatic test_faults();
    bit [31:0] addrs [3];
    bit [1:0]  codes [3];
    addrs[0] = 32'h6;    codes[0] = 2'b01;
    addrs[1] = 32'h1000; codes[1] = 2'b10;
    addrs[2] = 32'h1002; codes[2] = 2'b01;
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'h0000_0013;
    tick();
    load_en = 1'b0;
    resp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = addrs[i];
      tick();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_fault !== codes[i] || resp_data !== 32'h0 || resp_addr !== addrs[i]) begin
        n_fail++;
        $display("FAIL fault_code[%0d]: valid=%b fault=%b data=%h addr=%h, want 1/%b/0/%h",
                 i, resp_valid, resp_fault, resp_data, resp_addr, codes[i], addrs[i]);
      end
    end
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (fault_count !== 8'd3 || s_fault_count !== 2'd3) begin
      n_fail++;
      $display("FAIL fault_count3: got %0d/%0d want 3/3", fault_count, s_fault_count);
    end
    load_en = 1'b1; load_addr = 32'h1000; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    n_checks++;
    if (load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL load_err_pulse: got %b want 1", load_err);
    end
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_err_clear: got %b want 0", load_err);
    end
    n_checks++;
    if (resp_data !== 32'h0000_0013 || resp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL load_err_nowrite: data=%h fault=%b want 00000013/00", resp_data, resp_fault);
    end
    tick();
  endtask

  task automatic test_collision_saturation();
    resp_ready = 1'b1;
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    load_en = 1'b0;
    n_checks++;
    if (resp_data !== 32'h8C08_0000 || resp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_old: data=%h fault=%b want 8c080000/00", resp_data, resp_fault);
    end
    tick();
    n_checks++;
    if (resp_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL collision_new: data=%h want ffffffff", resp_data);
    end
    req_addr = 32'h3;
    tick();
    req_addr = 32'hFFFF_FFFC;
    tick();
    n_checks++;
    if (resp_fault !== 2'b10) begin
      n_fail++;
      $display("FAIL far_range: fault=%b want 10", resp_fault);
    end
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (fault_count !== 8'd5 || s_fault_count !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation: got %0d/%0d want 5/3", fault_count, s_fault_count);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    resp_ready = 1'b1;
    load_en = 1'b1; load_addr = 32'hC; load_data = 32'h1; load_par_flip = 1'b1;
    tick();
    load_addr = 32'h10; load_par_flip = 1'b0;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_addr = 32'h10;
    n_checks++;
    if (resp_fault !== 2'b11 || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL parity_bad: fault=%b data=%h want 11/0", resp_fault, resp_data);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (resp_fault !== 2'b00 || resp_data !== 32'h1) begin
      n_fail++;
      $display("FAIL parity_good: fault=%b data=%h want 00/1", resp_fault, resp_data);
    end
    n_checks++;
    if (fault_count !== 8'(sat(m_faults, 255))) begin
      n_fail++;
      $display("FAIL parity_count: got %0d want %0d", fault_count, sat(m_faults, 255));
    end
    tick();
  endtask
`endif

  task automatic test_mid_reset();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || fault_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h fault_count=%0d want 0/0/0", resp_valid, resp_data, fault_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit [31:0] a;
    int r;
    load_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_addr = 32'(i) << 2;
      load_data = $urandom();
      tick();
    end
    load_en = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 15)) << 2;
      else if (r < 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r < 9) a = 32'(DEPTH + $urandom_range(0, 20)) << 2;
      else            a = ($urandom() & 32'hFFFF_FFFC) | 32'h8000_0000;
      req_addr   = a;
      req_valid  = ($urandom_range(0, 9) < 7);
      resp_ready = ($urandom_range(0, 9) < 7);
      load_en    = ($urandom_range(0, 9) < 2);
      r = $urandom_range(0, 9);
      if (r < 7)      load_addr = 32'($urandom_range(0, 15)) << 2;
      else if (r < 9) load_addr = 32'(DEPTH + $urandom_range(0, 3)) << 2;
      else            load_addr = 32'h5;
      load_data = $urandom();
      #1;
      n_checks++;
      if (req_ready !== (!m_valid || resp_ready)) begin
        n_fail++;
        $display("FAIL rnd_req_ready[%0d]: got %b want %b", n, req_ready, (!m_valid || resp_ready));
      end
      tick();
      n_checks++;
      if (resp_valid !== m_valid || (m_valid &&
          (resp_data !== m_data || resp_addr !== m_addr || resp_fault !== m_fault))) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: valid=%b data=%h addr=%h fault=%b want %b/%h/%h/%b",
                 n, resp_valid, resp_data, resp_addr, resp_fault, m_valid, m_data, m_addr, m_fault);
      end
      n_checks++;
      if (fault_count !== 8'(sat(m_faults, 255)) || s_fault_count !== 2'(sat(m_faults, 3)) ||
          load_err !== m_lerr) begin
        n_fail++;
        $display("FAIL rnd_status[%0d]: fcnt=%0d sfcnt=%0d lerr=%b want %0d/%0d/%b",
                 n, fault_count, s_fault_count, load_err, sat(m_faults, 255), sat(m_faults, 3), m_lerr);
      end
      n_checks++;
      if (s_resp_valid !== m_valid || s_load_err !== m_lerr || s_req_ready !== (!m_valid || resp_ready) ||
          (m_valid && (s_resp_data !== m_data || s_resp_addr !== m_addr || s_resp_fault !== m_fault))) begin
        n_fail++;
        $display("FAIL rnd_sat_inst[%0d]: valid=%b data=%h addr=%h fault=%b lerr=%b want %b/%h/%h/%b/%b",
                 n, s_resp_valid, s_resp_data, s_resp_addr, s_resp_fault, s_load_err,
                 m_valid, m_data, m_addr, m_fault, m_lerr);
      end
    end
    req_valid = 1'b0; load_en = 1'b0; resp_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_faults();
    test_collision_saturation();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised successor to the single-port instruction memory: word-organised instruction store with a byte-addressed fetch port.
- Fetch port has a valid/ready request and response handshake, a registered one-cycle read, and address-fault reporting.
- A separate program-load write port fills the store before or during execution.
- Sits between the CPU fetch stage and the program loader.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses on the fetch and load ports.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 1024, number of words; need not be a power of two.
- FCNT_WIDTH, 8, width of the saturating fault counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  fetch request accepted this cycle when high together with req_valid.
- req_addr  input  ADDR_WIDTH  fetch byte address.
- resp_valid  output  1  response held.
- resp_ready  input  1  consumer takes the response.
- resp_data  output  DATA_WIDTH  instruction word; 0 on fault.
- resp_addr  output  ADDR_WIDTH  byte address of the request being answered.
- resp_fault  output  2  00 ok, 01 misaligned, 10 out-of-range, 11 parity (optional feature only).
- load_en  input  1  write strobe.
- load_addr  input  ADDR_WIDTH  byte address for the write.
- load_data  input  DATA_WIDTH  word to write.
- load_err  output  1  one-cycle pulse, cycle after a rejected load.
- fault_count  output  FCNT_WIDTH  number of faulted responses issued.

Behaviour:
- Reset (async, rst_n low): resp_valid=0, resp_data=0, resp_addr=0, resp_fault=00, load_err=0, fault_count=0. Memory contents are not reset.
- Reset mid-operation drops any held response immediately.
- Word index = req_addr >> 2.
- Misaligned: req_addr[1:0] != 0. Out-of-range: index >= DEPTH. Misaligned takes precedence over out-of-range.
- req_ready = !resp_valid || resp_ready (single-entry response register; full throughput when the consumer never stalls).
- Accept = req_valid && req_ready. On accept at edge N, the following are valid from edge N+1:
  - resp_valid=1, resp_addr=req_addr, resp_fault=code.
  - resp_data = mem[index] if code is 00, else 0.
- Latency is exactly 1 cycle.
- No accept while resp_ready=1: resp_valid clears at the next edge.
- Stall (resp_valid=1, resp_ready=0): resp_data, resp_addr and resp_fault hold stable; req_ready=0.
- Back-to-back: with resp_ready=1 and req_valid held high, one response is issued per cycle in request order.
- Load: on load_en, if load_addr is aligned and in range, mem[load_addr>>2] <= load_data at the edge. Otherwise no write, and load_err=1 for the next cycle only.
- Same-edge load and fetch to the same word: the fetch returns the old data (read-before-write). The new data is visible to fetches accepted on later edges.
- fault_count increments on each accept whose code is not 00, and saturates at all-ones.
- Fetch and load are independent; both may act on the same edge.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- With the macro defined:
  - Each word stores an extra even-parity bit, computed from load_data on write.
  - On a fetch that is aligned and in range, a parity mismatch gives resp_fault=11, resp_data=0, and fault_count increments.
  - A test-only input load_par_flip (1 bit) inverts the stored parity bit on that write.
- Without the macro:
  - No parity storage and no load_par_flip port.
  - Code 11 is never produced.

Test Plan:
- Reset: hold rst_n low, then release -> resp_valid=0, resp_data=0, fault_count=0, req_ready=1.
- Load then fetch: load 0x00000004<-0x8C080000 and 0x00000008<-0x20090005; fetch 0x4 then 0x8 back-to-back with resp_ready=1 -> responses 0x8C080000 then 0x20090005 on consecutive cycles, resp_fault=00, 1-cycle latency each.
- Backpressure: fetch 0x4 with resp_ready=0 for 3 cycles -> resp_data holds 0x8C080000 and req_ready=0 throughout; raising resp_ready completes the transfer and the next request is accepted that same cycle.
- Faults: fetch 0x6 -> fault 01, data 0; fetch 0x1000 (DEPTH=1024) -> fault 10; fetch 0x1002 -> fault 01; fault_count=3. Load to 0x1000 -> load_err pulses 1 cycle, no write.
- Collision and saturation: load 0x4<-0xFFFFFFFF on the same edge as a fetch of 0x4 -> response 0x8C080000; the next fetch of 0x4 returns 0xFFFFFFFF. With FCNT_WIDTH=2, 5 faulted fetches -> fault_count=3.
- Parity (IMEM_PARITY_EN): load 0xC <- 0x1 with load_par_flip=1, fetch 0xC -> resp_fault=11, resp_data=0.
